spic_slave: RTL and testbench

SPI responder (slave) for the spic subsystem: it sits at the far end of the SPI bus driven by the spic master and executes instructions against a local register file. It decodes each SPI frame into type, size and address, then either captures write data from MOSI or shifts read data out on MISO. SPI pins are oversampled in the single system clock domain, so the block has no second clock.

---
 rtl/spic_slave.sv | 252 +++++++++++++++++++++++++
 tb/tb_spic_slave.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/spic_slave.sv
// spic_slave: SPI mode-0 responder with a local register file.
//
// Each frame (ss_n low) carries a command word {T, SIZE[1:0], ADDR} followed by
// a data field of 8/16/32 bits. T=1 writes the captured MOSI bits into the low
// bits of reg[ADDR]. T=0 shifts reg[ADDR] out on MISO, MSB first. SIZE=11 is
// reserved and the rest of the frame is ignored.
// All SPI pins are oversampled in the clk domain.
//
// Parameters:
//   DWIDTH      register / maximum data-field width (must be 32)
//   AWIDTH      address width; the register file has 2**AWIDTH words
//
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   spi_sclk    SPI clock (CPOL=0, CPHA=0)
//   spi_ss_n    slave select, active low
//   spi_mosi    master-out data, MSB first
//   spi_miso    slave-out data, MSB first
//   spi_miso_oe MISO output enable, high only while read data is shifted
//   wr_strobe   one-cycle pulse when a register write commits
//   rd_strobe   one-cycle pulse when read data is loaded for shifting
//   last_addr   address of the most recently decoded command
//   frame_err   one-cycle pulse on an aborted or reserved-size frame
module spic_slave #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk,
    input  logic              spi_ss_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              wr_strobe,
    output logic              rd_strobe,
    output logic [AWIDTH-1:0] last_addr,
    output logic              frame_err
);

    localparam int CW    = 3 + AWIDTH;
    localparam int CNT_W = 6;
    localparam int NREGS = 2 ** AWIDTH;

    typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, DRAIN} state_t;

    state_t state_q, state_d;

    logic [2:0]        sclk_sync;
    logic [2:0]        ss_sync;
    logic [1:0]        mosi_sync;
    logic              sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_bit;

    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  n_bits;
    logic [1:0]        size_q;
    logic [CW-2:0]     cmd_sr;
    logic [CW-1:0]     cmd_word;
    logic              cmd_t;
    logic [1:0]        cmd_size;
    logic [AWIDTH-1:0] cmd_addr;
    logic [DWIDTH-2:0] wdata_sr;
    logic [DWIDTH-1:0] wr_word;
    logic [DWIDTH-1:0] wr_mask;
    logic [DWIDTH-1:0] rd_sr;
    logic [DWIDTH-1:0] regs [NREGS];

    logic              cmd_done, wr_done, rd_done, abort;

    function automatic logic [CNT_W-1:0] size_bits(input logic [1:0] sz);
        case (sz)
            2'b00:   return CNT_W'(8);
            2'b01:   return CNT_W'(16);
            default: return CNT_W'(32);
        endcase
    endfunction

    function automatic logic [DWIDTH-1:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   return {{(DWIDTH-8){1'b0}}, 8'hFF};
            2'b01:   return {{(DWIDTH-16){1'b0}}, 16'hFFFF};
            default: return {DWIDTH{1'b1}};
        endcase
    endfunction

    // Places the low N bits of a register at the top of the shift register.
    function automatic logic [DWIDTH-1:0] left_align(input logic [DWIDTH-1:0] v,
                                                     input logic [1:0] sz);
        case (sz)
            2'b00:   return {v[7:0], {(DWIDTH-8){1'b0}}};
            2'b01:   return {v[15:0], {(DWIDTH-16){1'b0}}};
            default: return v;
        endcase
    endfunction

    // Pin synchronisers. ss_n resets to the "low" level so that a frame
    // already running when reset releases produces no falling edge; the
    // slave only starts on a fresh ss_n fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            ss_sync   <= '0;
            mosi_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], spi_sclk};
            ss_sync   <= {ss_sync[1:0], spi_ss_n};
            mosi_sync <= {mosi_sync[0], spi_mosi};
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign ss_rise   = ss_sync[1] & ~ss_sync[2];
    assign ss_fall   = ~ss_sync[1] & ss_sync[2];
    assign mosi_bit  = mosi_sync[1];

    assign cmd_word = {cmd_sr, mosi_bit};
    assign cmd_t    = cmd_word[CW-1];
    assign cmd_size = cmd_word[CW-2:CW-3];
    assign cmd_addr = cmd_word[AWIDTH-1:0];
    assign n_bits   = size_bits(size_q);
    assign wr_mask  = size_mask(size_q);
    assign wr_word  = {wdata_sr, mosi_bit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cmd_done = 1'b0;
        wr_done  = 1'b0;
        rd_done  = 1'b0;
        abort    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_fall) state_d = CMD;
            end
            CMD: begin
                if (ss_rise) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end else if (sclk_rise && bit_cnt == CNT_W'(CW-1)) begin
                    cmd_done = 1'b1;
                    if (cmd_size == 2'b11) state_d = DRAIN;
                    else if (cmd_t)        state_d = WDATA;
                    else                   state_d = RDATA;
                end
            end
            WDATA: begin
                if (ss_rise) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end else if (sclk_rise && bit_cnt == n_bits - CNT_W'(1)) begin
                    wr_done = 1'b1;
                    state_d = DRAIN;
                end
            end
            RDATA: begin
                // Read stays here until the falling edge after the last data
                // bit, so that edge can release MISO.
                if (ss_rise) begin
                    state_d = IDLE;
                    abort   = (bit_cnt < n_bits);
                end else if (sclk_fall && bit_cnt == n_bits) begin
                    rd_done = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (ss_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt     <= '0;
            size_q      <= '0;
            cmd_sr      <= '0;
            wdata_sr    <= '0;
            rd_sr       <= '0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            wr_strobe   <= 1'b0;
            rd_strobe   <= 1'b0;
            frame_err   <= 1'b0;
            last_addr   <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            wr_strobe <= 1'b0;
            rd_strobe <= 1'b0;
            frame_err <= 1'b0;

            if (state_q == IDLE && ss_fall) bit_cnt <= '0;

            if (state_q == CMD && sclk_rise) begin
                cmd_sr  <= cmd_word[CW-2:0];
                bit_cnt <= bit_cnt + CNT_W'(1);
            end

            if (cmd_done) begin
                bit_cnt   <= '0;
                size_q    <= cmd_size;
                last_addr <= cmd_addr;
                if (cmd_size == 2'b11) begin
                    frame_err <= 1'b1;
                end else if (!cmd_t) begin
                    rd_sr     <= left_align(regs[cmd_addr], cmd_size);
                    rd_strobe <= 1'b1;
                end
            end

            if (state_q == WDATA && sclk_rise) begin
                wdata_sr <= wr_word[DWIDTH-2:0];
                bit_cnt  <= bit_cnt + CNT_W'(1);
            end

            // Only the low N bits are replaced; upper bits keep their value.
            if (wr_done) begin
                regs[last_addr] <= (regs[last_addr] & ~wr_mask) | (wr_word & wr_mask);
                wr_strobe       <= 1'b1;
            end

            if (state_q == RDATA && sclk_rise) bit_cnt <= bit_cnt + CNT_W'(1);

            if (state_q == RDATA && sclk_fall && !ss_rise) begin
                if (rd_done) begin
                    spi_miso    <= 1'b0;
                    spi_miso_oe <= 1'b0;
                end else begin
                    spi_miso    <= rd_sr[DWIDTH-1];
                    rd_sr       <= {rd_sr[DWIDTH-2:0], 1'b0};
                    spi_miso_oe <= 1'b1;
                end
            end

            if (ss_rise) begin
                spi_miso    <= 1'b0;
                spi_miso_oe <= 1'b0;
            end

            if (abort) frame_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spic_slave.sv
// tb_spic_slave: randomized bench for spic_slave, checked against a
// behavioural register-file model held in the bench.
module tb_spic_slave;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       spi_sclk, spi_ss_n, spi_mosi;
    logic       spi_miso, spi_miso_oe, wr_strobe, rd_strobe, frame_err;
    logic [3:0] last_addr;

    int n_checks = 0;
    int n_pass   = 0;
    int wr_cnt = 0, rd_cnt = 0, fe_cnt = 0;

    logic [31:0] model [16];
    logic [3:0]  exp_last;

    spic_slave #(.DWIDTH(32), .AWIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_sclk   (spi_sclk),
        .spi_ss_n   (spi_ss_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .wr_strobe  (wr_strobe),
        .rd_strobe  (rd_strobe),
        .last_addr  (last_addr),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // Pulse counters; sampled on the active edge so each high cycle counts once.
    always @(posedge clk) begin
        if (wr_strobe) wr_cnt++;
        if (rd_strobe) rd_cnt++;
        if (frame_err) fe_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic int nbits_of(input logic [1:0] sz);
        return (sz == 2'b00) ? 8 : (sz == 2'b01) ? 16 : 32;
    endfunction

    function automatic logic [31:0] mask_of(input logic [1:0] sz);
        return (sz == 2'b00) ? 32'h0000_00FF : (sz == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

    // Drives one frame starting at the current negedge. ndata data clocks are
    // sent after the command; MISO/oe are sampled just before each data rise.
    task automatic spi_frame(input bit t, input logic [1:0] sz, input logic [3:0] a,
                             input logic [31:0] d, input int ndata, input int half,
                             input int gap, output logic [31:0] rdv, output int oe_hi);
        logic [6:0] cmd;
        int nb;
        cmd   = {t, sz, a};
        nb    = nbits_of(sz);
        rdv   = '0;
        oe_hi = 0;
        spi_ss_n = 1'b0;
        repeat (half) @(negedge clk);
        for (int i = 0; i < 7 + ndata; i++) begin
            if (i < 7)  spi_mosi = cmd[6-i];
            else if (t) spi_mosi = d[nb-1-(i-7)];
            else        spi_mosi = 1'($urandom);
            repeat (half) @(negedge clk);
            if (i >= 7) begin
                rdv = {rdv[30:0], spi_miso};
                if (spi_miso_oe) oe_hi++;
            end
            spi_sclk = 1'b1;
            repeat (half) @(negedge clk);
            spi_sclk = 1'b0;
        end
        repeat (half) @(negedge clk);
        spi_ss_n = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_frame(input string tag, input bit t, input logic [1:0] sz,
                            input logic [3:0] a, input logic [31:0] d, input int ndata,
                            input int half, input int gap);
        int wr0, rd0, fe0, oe_hi, nb;
        logic [31:0] rdv, mask;
        bit complete;
        nb   = nbits_of(sz);
        mask = mask_of(sz);
        wr0 = wr_cnt; rd0 = rd_cnt; fe0 = fe_cnt;
        spi_frame(t, sz, a, d, ndata, half, gap, rdv, oe_hi);
        complete = (sz != 2'b11) && (ndata >= nb);
        exp_last = a;
        if (complete && !t) check({tag, "/rdata"}, rdv & mask, model[a] & mask);
        if (complete && t)  model[a] = (model[a] & ~mask) | (d & mask);
        check({tag, "/wr_pulses"}, wr_cnt - wr0, (complete && t) ? 1 : 0);
        check({tag, "/rd_pulses"}, rd_cnt - rd0, (sz != 2'b11 && !t) ? 1 : 0);
        check({tag, "/ferr_pulses"}, fe_cnt - fe0, complete ? 0 : 1);
        check({tag, "/oe_bits"}, oe_hi, (sz != 2'b11 && !t) ? ndata : 0);
        check({tag, "/last_addr"}, last_addr, exp_last);
        check({tag, "/idle_oe"}, spi_miso_oe, 0);
        check({tag, "/idle_miso"}, spi_miso, 0);
    endtask

    initial begin
        logic [31:0] rdv;
        int oe_hi, wr0, rd0, fe0;
        rst_n = 1'b0; spi_sclk = 1'b0; spi_ss_n = 1'b1; spi_mosi = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = '0;
        repeat (5) @(negedge clk);
        check("reset/miso", spi_miso, 0);
        check("reset/oe", spi_miso_oe, 0);
        check("reset/wr_strobe", wr_strobe, 0);
        check("reset/rd_strobe", rd_strobe, 0);
        check("reset/frame_err", frame_err, 0);
        check("reset/last_addr", last_addr, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        do_frame("wr32_a3", 1'b1, 2'b10, 4'd3, 32'hDEADBEEF, 32, 5, 6);
        do_frame("rd32_a3", 1'b0, 2'b10, 4'd3, 32'h0, 32, 5, 6);
        do_frame("wr8_a3", 1'b1, 2'b00, 4'd3, 32'h0000005A, 8, 5, 6);
        do_frame("rd32_a3_merged", 1'b0, 2'b10, 4'd3, 32'h0, 32, 5, 6);
        check("model_a3", model[3], 32'hDEADBE5A);
        do_frame("rd16_a3", 1'b0, 2'b01, 4'd3, 32'h0, 16, 5, 6);
        do_frame("wr_abort_a5", 1'b1, 2'b10, 4'd5, 32'h12345678, 10, 5, 6);
        do_frame("rd32_a5", 1'b0, 2'b10, 4'd5, 32'h0, 32, 5, 6);
        do_frame("reserved_a7", 1'b0, 2'b11, 4'd7, 32'h0, 32, 5, 6);
        do_frame("wr_min_a0", 1'b1, 2'b10, 4'd0, 32'hA5C3_0F96, 32, 4, 4);
        do_frame("wr_min_a15", 1'b1, 2'b10, 4'd15, 32'h6996_1234, 32, 4, 4);
        do_frame("rd_min_a0", 1'b0, 2'b10, 4'd0, 32'h0, 32, 4, 4);
        do_frame("rd_min_a15", 1'b0, 2'b10, 4'd15, 32'h0, 32, 4, 4);

        for (int k = 0; k < 30; k++) begin
            int op, nb, nd;
            logic [1:0] sz;
            logic [3:0] a;
            logic [31:0] d;
            op = $urandom_range(0, 9);
            sz = 2'($urandom_range(0, 2));
            a  = 4'($urandom);
            d  = $urandom;
            nb = nbits_of(sz);
            if (op == 0)      do_frame("rand_reserved", 1'($urandom), 2'b11, a, d, 32,
                                       $urandom_range(4, 6), $urandom_range(4, 8));
            else if (op == 1) begin
                nd = $urandom_range(1, nb - 1);
                do_frame("rand_wr_abort", 1'b1, sz, a, d, nd, $urandom_range(4, 6),
                         $urandom_range(4, 8));
            end
            else if (op <= 5) do_frame("rand_wr", 1'b1, sz, a, d, nb, $urandom_range(4, 6),
                                       $urandom_range(4, 8));
            else              do_frame("rand_rd", 1'b0, sz, a, d, nb, $urandom_range(4, 6),
                                       $urandom_range(4, 8));
        end

        // Reset in the middle of a read data phase.
        wr0 = wr_cnt; rd0 = rd_cnt; fe0 = fe_cnt;
        fork
            spi_frame(1'b0, 2'b10, 4'd3, 32'h0, 32, 5, 6, rdv, oe_hi);
            begin
                repeat (5 + 17 * 10 + 3) @(negedge clk);
                check("rst_mid/oe_before", spi_miso_oe, 1);
                rst_n = 1'b0;
                #1;
                check("rst_mid/miso", spi_miso, 0);
                check("rst_mid/oe", spi_miso_oe, 0);
                check("rst_mid/last_addr", last_addr, 0);
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        for (int i = 0; i < 16; i++) model[i] = '0;
        check("rst_mid/wr_pulses", wr_cnt - wr0, 0);
        check("rst_mid/rd_pulses", rd_cnt - rd0, 1);
        check("rst_mid/ferr_pulses", fe_cnt - fe0, 0);
        check("rst_mid/oe_after", spi_miso_oe, 0);
        do_frame("post_rst_rd_a3", 1'b0, 2'b10, 4'd3, 32'h0, 32, 5, 6);
        do_frame("post_rst_rd_a0", 1'b0, 2'b10, 4'd0, 32'h0, 32, 5, 6);
        do_frame("post_rst_rd_a15", 1'b0, 2'b10, 4'd15, 32'h0, 32, 5, 6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
